mmu_refill: RTL and testbench

//  Hardware refill engine for the mmu: on a TLB miss it fetches the page-table

---
 rtl/mmu_refill.sv | 162 ++++++++++++++++
 tb/tb_mmu_refill.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_refill.sv
// Hardware TLB refill engine: on a TLB miss, fetch the PTE from memory,
// load it through the mmu register write port, then let the core retry.
// Faults that cannot be filled, protection faults and bus errors become a trap.
module mmu_refill #(
   parameter int unsigned RV      = 16,
   parameter int unsigned PA      = RV,
   parameter int unsigned VA      = RV,
   parameter int unsigned NMMU    = 8,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          walk_enable,
   input  logic          mmu_fault,
   input  logic          mmu_miss_fault,
   input  logic          mmu_prot_fault,
   input  logic [RV-1:0] mmu_reg_read,
   input  logic [PA-1:0] ptbr,
   output logic          reg_write,
   output logic [RV-1:0] reg_data,
   output logic          mem_req,
   output logic [PA-1:0] mem_addr,
   input  logic          mem_ack,
   input  logic          mem_rvalid,
   input  logic [RV-1:0] mem_rdata,
   input  logic          mem_err,
   output logic          busy,
   output logic          refill_done,
   output logic          trap,
   output logic [1:0]    trap_cause
);

   localparam int unsigned VW = $clog2(NMMU);
   localparam int unsigned IW = VW + 2;
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] CauseMiss = 2'd1;
   localparam logic [1:0] CauseProt = 2'd2;
   localparam logic [1:0] CauseBus  = 2'd3;

   typedef enum logic [2:0] {StIdle, StCapt, StReq, StWait, StLoad} state_e;

   state_e        state_q, state_d;
   logic [PA-1:0] mem_addr_q, mem_addr_d;
   logic [RV-1:0] reg_data_q, reg_data_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          trap_q, trap_d;
   logic [1:0]    trap_cause_q, trap_cause_d;
   logic          refill_done_q, refill_done_d;

   logic [IW-1:0] idx;
   logic [PA-1:0] pte_off;
   logic          take_rsp;
   logic          unused_ok;

   // PTE index {ins, sup, vpn}; each PTE is one 16-bit word, hence the shift by one
   assign idx       = {mmu_reg_read[3], mmu_reg_read[2], mmu_reg_read[RV-1 -: VW]};
   assign pte_off   = {{(PA-IW-1){1'b0}}, idx, 1'b0};
   assign unused_ok = ^{mmu_reg_read, mem_rdata[0]};

   // Response consumed in WAIT, or in REQ when ack and data arrive together
   assign take_rsp = ((state_q == StReq) && mem_ack && mem_rvalid) ||
                     ((state_q == StWait) && mem_rvalid);

   // Next-state and registered-output logic
   always_comb begin
      state_d       = state_q;
      mem_addr_d    = mem_addr_q;
      reg_data_d    = reg_data_q;
      cnt_d         = cnt_q;
      trap_d        = 1'b0;
      trap_cause_d  = trap_cause_q;
      refill_done_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (mmu_fault) begin
               if (mmu_prot_fault) begin
                  trap_d       = 1'b1;
                  trap_cause_d = CauseProt;
               end else if (mmu_miss_fault) begin
                  if (walk_enable) begin
                     state_d = StCapt;
                  end else begin
                     trap_d       = 1'b1;
                     trap_cause_d = CauseMiss;
                  end
               end
            end
         end

         // Fault registers are valid one cycle after the fault strobe
         StCapt: begin
            mem_addr_d = ptbr + pte_off;
            cnt_d      = '0;
            state_d    = StReq;
         end

         StReq, StWait: begin
            cnt_d = cnt_q + CW'(1);
            if (take_rsp) begin
               if (mem_err) begin
                  trap_d       = 1'b1;
                  trap_cause_d = CauseBus;
                  state_d      = StIdle;
               end else if (!mem_rdata[1]) begin
                  trap_d       = 1'b1;
                  trap_cause_d = CauseMiss;
                  state_d      = StIdle;
               end else begin
                  reg_data_d = {mem_rdata[RV-1:1], 1'b1};
                  state_d    = StLoad;
               end
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               trap_d       = 1'b1;
               trap_cause_d = CauseBus;
               state_d      = StIdle;
            end else if ((state_q == StReq) && mem_ack) begin
               state_d = StWait;
            end
         end

         StLoad: begin
            refill_done_d = 1'b1;
            state_d       = StIdle;
         end

         default: state_d = StIdle;
      endcase
   end

   // State and output registers, synchronous active-high reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         mem_addr_q    <= '0;
         reg_data_q    <= '0;
         cnt_q         <= '0;
         trap_q        <= 1'b0;
         trap_cause_q  <= '0;
         refill_done_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         mem_addr_q    <= mem_addr_d;
         reg_data_q    <= reg_data_d;
         cnt_q         <= cnt_d;
         trap_q        <= trap_d;
         trap_cause_q  <= trap_cause_d;
         refill_done_q <= refill_done_d;
      end
   end

   assign mem_req     = (state_q == StReq);
   assign reg_write   = (state_q == StLoad);
   assign busy        = (state_q != StIdle);
   assign mem_addr    = mem_addr_q;
   assign reg_data    = reg_data_q;
   assign trap        = trap_q;
   assign trap_cause  = trap_cause_q;
   assign refill_done = refill_done_q;

endmodule

// File: tb/tb_mmu_refill.sv
// Scoreboard bench for mmu_refill: stimulus pushes expected events
// (request, register write, refill done, trap) with their cycle; a monitor
// pops and compares each event the DUT presents.
module tb_mmu_refill;

   localparam int TIMEOUT = 255;

   localparam int KReq  = 0;
   localparam int KWr   = 1;
   localparam int KDone = 2;
   localparam int KTrap = 3;

   localparam int MZero  = 0;  // ack at once, data next cycle
   localparam int MSame  = 1;  // ack and data in the same cycle
   localparam int MNoAck = 2;  // never ack
   localparam int MLate  = 3;  // ack at once, data four cycles later

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        walk_enable = 1'b1;
   logic        mmu_fault = 1'b0;
   logic        mmu_miss_fault = 1'b0;
   logic        mmu_prot_fault = 1'b0;
   logic [15:0] mmu_reg_read = '0;
   logic [15:0] ptbr = '0;
   logic        reg_write;
   logic [15:0] reg_data;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [15:0] mem_rdata = '0;
   logic        mem_err = 1'b0;
   logic        busy;
   logic        refill_done;
   logic        trap;
   logic [1:0]  trap_cause;

   mmu_refill #(
      .RV(16), .PA(16), .VA(16), .NMMU(8), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .walk_enable(walk_enable),
      .mmu_fault(mmu_fault), .mmu_miss_fault(mmu_miss_fault),
      .mmu_prot_fault(mmu_prot_fault), .mmu_reg_read(mmu_reg_read), .ptbr(ptbr),
      .reg_write(reg_write), .reg_data(reg_data), .mem_req(mem_req),
      .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .mem_err(mem_err), .busy(busy),
      .refill_done(refill_done), .trap(trap), .trap_cause(trap_cause)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          kind;
      logic [15:0] val;
      int          cyc;
   } ev_t;

   ev_t         exp_q[$];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   int          mem_mode = MZero;
   logic [15:0] pte = '0;
   logic        pte_err = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
   endtask

   task automatic push(input int kind, input logic [15:0] val, input int at);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      e.cyc  = at;
      exp_q.push_back(e);
   endtask

   task automatic obs(input int kind, input logic [15:0] val);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_checks++;
         $display("FAIL unexpected event kind %0d val %0h at cycle %0d", kind, val, cyc);
      end else begin
         e = exp_q.pop_front();
         check("event kind", kind, e.kind);
         check("event value", val, e.val);
         check("event cycle", cyc, e.cyc);
      end
   endtask

   // Monitor: turn DUT outputs into events and score them
   initial begin
      logic prev_req;
      prev_req = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (mem_req && !prev_req) obs(KReq, mem_addr);
            if (reg_write) obs(KWr, reg_data);
            if (refill_done) begin
               obs(KDone, 16'h0);
               check("busy low with refill_done", busy, 0);
            end
            if (trap) begin
               obs(KTrap, {14'h0, trap_cause});
               check("busy low with trap", busy, 0);
               check("no refill_done with trap", refill_done, 0);
            end
         end
         prev_req = mem_req;
      end
   end

   // Memory responder
   initial begin
      int pend;
      pend = 0;
      forever begin
         @(posedge clk);
         #1;
         mem_ack    = 1'b0;
         mem_rvalid = 1'b0;
         mem_err    = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = pte;
               mem_err    = pte_err;
            end
         end
         if (mem_req && mem_mode != MNoAck) begin
            mem_ack = 1'b1;
            if (mem_mode == MSame) begin
               mem_rvalid = 1'b1;
               mem_rdata  = pte;
               mem_err    = pte_err;
            end else begin
               pend = (mem_mode == MLate) ? 4 : 1;
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One-cycle fault strobe; t is the cycle in which it is presented
   task automatic fault(input logic miss, input logic prot, output int t);
      mmu_fault      = 1'b1;
      mmu_miss_fault = miss;
      mmu_prot_fault = prot;
      t = cyc;
      step(1);
      mmu_fault      = 1'b0;
      mmu_miss_fault = 1'b0;
      mmu_prot_fault = 1'b0;
   endtask

   initial begin
      int t;
      step(3);
      reset = 1'b0;
      check("reset busy", busy, 0);
      check("reset mem_req", mem_req, 0);
      check("reset reg_write", reg_write, 0);
      check("reset trap", trap, 0);
      check("reset refill_done", refill_done, 0);
      check("reset trap_cause", trap_cause, 0);
      check("reset mem_addr", mem_addr, 0);
      check("reset reg_data", reg_data, 0);

      // Successful walk; fault regs only valid the cycle after the strobe
      ptbr = 16'h1000; mmu_reg_read = 16'hFFFF; mem_mode = MZero; pte = 16'hA006; pte_err = 0;
      fault(1, 0, t);
      push(KReq, 16'h101A, t + 2);
      push(KWr, 16'hA007, t + 4);
      push(KDone, 16'h0, t + 5);
      mmu_reg_read = 16'hA004;
      mmu_fault = 1'b1; mmu_prot_fault = 1'b1;  // ignored while busy
      step(1);
      mmu_fault = 1'b0; mmu_prot_fault = 1'b0;
      check("busy during walk", busy, 1);
      step(3);
      check("busy after refill", busy, 0);
      step(4);

      // Invalid PTE -> miss trap
      ptbr = 16'h2000; mmu_reg_read = 16'hE008; pte = 16'hA004;
      fault(1, 0, t);
      push(KReq, 16'h202E, t + 2);
      push(KTrap, 16'h1, t + 4);
      step(8);

      // Protection has priority over miss
      fault(1, 1, t);
      push(KTrap, 16'h2, t + 1);
      step(6);

      // Software refill mode
      walk_enable = 1'b0;
      fault(1, 0, t);
      push(KTrap, 16'h1, t + 1);
      step(6);
      walk_enable = 1'b1;

      // Fault with no qualifier is ignored
      fault(0, 0, t);
      check("no-qualifier fault idle", busy, 0);
      step(6);

      // Bus error, with the PTE address wrapping past 0xFFFF
      ptbr = 16'hFFF0; mmu_reg_read = 16'hE00C; pte = 16'hA006; pte_err = 1;
      fault(1, 0, t);
      push(KReq, 16'h002E, t + 2);
      push(KTrap, 16'h3, t + 4);
      step(8);
      pte_err = 0;

      // Ack and data in the same cycle
      ptbr = 16'h0100; mmu_reg_read = 16'h0000; pte = 16'h5552; mem_mode = MSame;
      fault(1, 0, t);
      push(KReq, 16'h0100, t + 2);
      push(KWr, 16'h5553, t + 3);
      push(KDone, 16'h0, t + 4);
      step(8);

      // Request never acknowledged -> timeout trap
      ptbr = 16'h1000; mmu_reg_read = 16'hA004; mem_mode = MNoAck;
      fault(1, 0, t);
      push(KReq, 16'h101A, t + 2);
      push(KTrap, 16'h3, t + 2 + TIMEOUT);
      step(1 + TIMEOUT);
      check("timeout cycle reached", cyc, t + 2 + TIMEOUT);
      check("mem_req dropped on timeout", mem_req, 0);
      check("idle after timeout", busy, 0);
      step(6);

      // Reset while waiting for data; the late response must be ignored
      pte = 16'hA006; mem_mode = MLate;
      fault(1, 0, t);
      push(KReq, 16'h101A, t + 2);
      step(3);
      check("busy in wait", busy, 1);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      check("reset mid-walk busy", busy, 0);
      check("reset mid-walk mem_req", mem_req, 0);
      check("reset mid-walk mem_addr", mem_addr, 0);
      check("reset mid-walk reg_data", reg_data, 0);
      step(6);
      check("late response ignored reg_data", reg_data, 0);
      check("late response ignored busy", busy, 0);
      mem_mode = MZero;

      step(10);
      check("scoreboard drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
